// File: rtl/unreg_seq.sv
// unreg_seq: sequencing controller for the 16-bit nibble-rotate register slice.
//
// Owns the architectural register and accepts one command at a time over a
// valid/ready handshake.
// Each command becomes one of four per-cycle select controls: hold, clear,
// load or rotate. Multi-cycle rotations are driven by an internal down-counter.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for a command; cmd_ready=1
//   ROT    | one nibble-rotate step per edge until the count reaches its last step
//   DONE   | completion cycle; done=1, ops_cnt bumps on the exit edge
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle (state==IDLE)
//   cmd_op     in   0=NOP 1=CLR 2=LOAD 3=ROT
//   cmd_arg    in   rotate count (ROT only)
//   cmd_data   in   parallel load value (LOAD only)
//   reg_q      out  register contents
//   busy       out  command in progress (state != IDLE)
//   done       out  one-cycle completion pulse
//   ops_cnt    out  saturating count of completed commands

module unreg_seq #(
  parameter int CNT_W = 4,
  parameter int OPS_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [15:0]      cmd_data,
  output logic [15:0]      reg_q,
  output logic             busy,
  output logic             done,
  output logic [OPS_W-1:0] ops_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_CLR  = 2'd1,
    SEL_LOAD = 2'd2,
    SEL_ROT  = 2'd3
  } sel_t;

  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;
  localparam logic [1:0] OP_ROT  = 2'd3;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      data_q;
  logic [15:0]      data_d;
  logic [OPS_W-1:0] ops_q;
  logic             accept;
  sel_t             sel;

  // Each nibble rotates right by one bit, independently of its neighbours.
  function automatic logic [15:0] rot_step(input logic [15:0] v);
    return {v[12], v[15:13], v[8], v[11:9], v[4], v[7:5], v[0], v[3:1]};
  endfunction

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign reg_q     = data_q;
  assign ops_cnt   = ops_q;
  assign accept    = cmd_valid && (state_q == S_IDLE);

  // One-hot-by-construction select: rotate only in ROT, clear/load only at accept.
  always_comb begin
    sel = SEL_HOLD;
    if (state_q == S_ROT)
      sel = SEL_ROT;
    else if (accept && (cmd_op == OP_CLR))
      sel = SEL_CLR;
    else if (accept && (cmd_op == OP_LOAD))
      sel = SEL_LOAD;
  end

  always_comb begin
    data_d = data_q;
    case (sel)
      SEL_CLR:  data_d = 16'h0000;
      SEL_LOAD: data_d = cmd_data;
      SEL_ROT:  data_d = rot_step(data_q);
      default:  data_d = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= 16'h0000;
      ops_q   <= '0;
    end else begin
      data_q <= data_d;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            // ROT 0 completes immediately like the single-cycle opcodes.
            if ((cmd_op == OP_ROT) && (cmd_arg != '0)) begin
              cnt_q   <= cmd_arg;
              state_q <= S_ROT;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_ROT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1))
            state_q <= S_DONE;
        end
        S_DONE: begin
          if (ops_q != '1)
            ops_q <= ops_q + 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // OP_NOP is decoded implicitly: it takes the hold path straight to DONE.
  logic unused_nop;
  assign unused_nop = (OP_NOP == 2'd0);

endmodule

// File: tb/tb_unreg_seq.sv
module tb_unreg_seq;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_arg;
  logic [15:0] cmd_data;
  logic [15:0] reg_q;
  logic        busy;
  logic        done;
  logic [7:0]  ops_cnt;

  unreg_seq #(.CNT_W(4), .OPS_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .cmd_data  (cmd_data),
    .reg_q     (reg_q),
    .busy      (busy),
    .done      (done),
    .ops_cnt   (ops_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;

  typedef struct {
    logic [15:0] reg_v;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  arg;
    logic [15:0] data;
    logic [15:0] exp_reg;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_reg", {16'h0, reg_q}, {16'h0, e.reg_v});
        chk("done_latency", cyc - e.acc + 1, e.lat);
      end
    end
  end

  // Call at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] arg, input logic [15:0] data,
                       input logic [15:0] exp_reg, input int exp_lat);
    int k;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_data  = data;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back('{exp_reg, cyc + 1, exp_lat});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int nbusy);
    int k;
    nbusy = 0;
    k = 0;
    while (busy && k < 40) begin
      nbusy++;
      k++;
      @(negedge clk);
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  vec_t vecs[14];
  int   exp_ops;
  int   nb;
  int   acc[3];
  int   idx;
  int   done_before;
  logic [15:0] b2b_reg[3];
  logic [1:0]  b2b_op[3];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 4'd0; cmd_data = 16'h0;

    vecs[0]  = '{2'd2, 4'd0,  16'h1234, 16'h1234, 1};
    vecs[1]  = '{2'd2, 4'd0,  16'h8421, 16'h8421, 1};
    vecs[2]  = '{2'd3, 4'd1,  16'hFFFF, 16'h4218, 2};
    vecs[3]  = '{2'd3, 4'd3,  16'h0000, 16'h8421, 4};
    vecs[4]  = '{2'd2, 4'd7,  16'hA5C3, 16'hA5C3, 1};
    vecs[5]  = '{2'd3, 4'd0,  16'h0000, 16'hA5C3, 1};
    vecs[6]  = '{2'd3, 4'd4,  16'h0000, 16'hA5C3, 5};
    vecs[7]  = '{2'd3, 4'd5,  16'h0000, 16'h5A69, 6};
    vecs[8]  = '{2'd1, 4'd3,  16'hFFFF, 16'h0000, 1};
    vecs[9]  = '{2'd2, 4'd0,  16'hF00F, 16'hF00F, 1};
    vecs[10] = '{2'd3, 4'd2,  16'h0000, 16'hF00F, 3};
    vecs[11] = '{2'd2, 4'd0,  16'h1248, 16'h1248, 1};
    vecs[12] = '{2'd3, 4'd1,  16'h0000, 16'h8124, 2};
    vecs[13] = '{2'd3, 4'd15, 16'h0000, 16'h1248, 16};

    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_reg",   {16'h0, reg_q}, 32'h0);
    chk("rst_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_busy",  {31'h0, busy}, 32'd0);
    chk("rst_done",  {31'h0, done}, 32'd0);
    chk("rst_ops",   {24'h0, ops_cnt}, 32'd0);

    // Table: command, then busy length, final register and op count.
    exp_ops = 0;
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].arg, vecs[i].data, vecs[i].exp_reg, vecs[i].exp_lat);
      wait_idle(nb);
      exp_ops++;
      chk("vec_busy_cycles", nb, vecs[i].exp_lat);
      chk("vec_reg", {16'h0, reg_q}, {16'h0, vecs[i].exp_reg});
      chk("vec_ops", {24'h0, ops_cnt}, exp_ops);
      chk("vec_ready", {31'h0, cmd_ready}, 32'd1);
    end
    chk("sb_empty_table", sb.size(), 0);

    // Reset two cycles into ROT 15.
    issue(2'd2, 4'd0, 16'h1234, 16'h1234, 1);
    wait_idle(nb);
    issue(2'd3, 4'd15, 16'h0, 16'h0, 16);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    done_before = n_done;
    chk("midrst_reg",   {16'h0, reg_q}, 32'h0);
    chk("midrst_ready", {31'h0, cmd_ready}, 32'd1);
    chk("midrst_busy",  {31'h0, busy}, 32'd0);
    chk("midrst_ops",   {24'h0, ops_cnt}, 32'd0);
    repeat (20) @(negedge clk);
    chk("midrst_no_done", n_done - done_before, 0);
    chk("midrst_reg_after", {16'h0, reg_q}, 32'h0);

    // Back-to-back with cmd_valid held high: LOAD, CLR, NOP.
    b2b_op[0] = 2'd2; b2b_reg[0] = 16'hBEEF;
    b2b_op[1] = 2'd1; b2b_reg[1] = 16'h0000;
    b2b_op[2] = 2'd0; b2b_reg[2] = 16'h0000;
    idx = 0;
    cmd_valid = 1'b1;
    cmd_op = b2b_op[0]; cmd_arg = 4'd5; cmd_data = 16'hBEEF;
    for (int k = 0; k < 20 && idx < 3; k++) begin
      if (cmd_ready) begin
        acc[idx] = cyc + 1;
        sb.push_back('{b2b_reg[idx], cyc + 1, 1});
        idx++;
        @(negedge clk);
        if (idx < 3) cmd_op = b2b_op[idx];
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", idx, 3);
    chk("b2b_gap01", acc[1] - acc[0], 2);
    chk("b2b_gap12", acc[2] - acc[1], 2);
    wait_idle(nb);
    chk("b2b_reg", {16'h0, reg_q}, 32'h0);
    chk("b2b_ops", {24'h0, ops_cnt}, 32'd3);
    chk("sb_empty_b2b", sb.size(), 0);

    // Saturation: 300 NOPs over a loaded value.
    issue(2'd2, 4'd0, 16'h5A5A, 16'h5A5A, 1);
    wait_idle(nb);
    exp_ops = 4;
    chk("sat_start", {24'h0, ops_cnt}, exp_ops);
    for (int i = 0; i < 300; i++) begin
      issue(2'd0, 4'd9, 16'hFFFF, 16'h5A5A, 1);
      wait_idle(nb);
      if (exp_ops < 255) exp_ops++;
      chk("sat_ops", {24'h0, ops_cnt}, exp_ops);
    end
    chk("sat_final", {24'h0, ops_cnt}, 32'd255);
    chk("sat_reg", {16'h0, reg_q}, 32'h5A5A);
    repeat (3) @(negedge clk);
    chk("sb_empty_end", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
